// File: rtl/delay_timer_pkg.sv
// Shared types and default constants for the serially programmed delay timer.
package delay_timer_pkg;

   localparam int           UNIT_CYCLES = 1000;
   localparam int           DELAY_W     = 4;
   localparam int           PAT_W       = 4;
   localparam logic [3:0]   START_PAT   = 4'b1101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage : delay_timer_pkg

// File: rtl/start_seq_det.sv
// Overlapping serial start-pattern detector; history is held only while enabled
// and is wiped on a match so stale bits never feed a later match.
module start_seq_det #(
   parameter int                 PAT_W     = delay_timer_pkg::PAT_W,
   parameter logic [PAT_W-1:0]   START_PAT = delay_timer_pkg::START_PAT
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic data,
   output logic match
);

   logic [PAT_W-1:0] hist_q;
   logic [PAT_W-1:0] hist_d;
   logic [PAT_W-1:0] window;

   // Window includes the bit being sampled this edge, so match fires on the final bit.
   assign window = (hist_q << 1) | PAT_W'(data);
   assign match  = enable && (window == START_PAT);

   always_comb begin
      hist_d = '0;
      if (enable && !match) begin
         hist_d = window;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

endmodule : start_seq_det

// File: rtl/delay_timer.sv
// Serially programmed delay timer: waits for a start pattern, loads a delay field,
// then runs for (delay+1) units of UNIT_CYCLES clocks and flags completion.
module delay_timer #(
   parameter int                 UNIT_CYCLES = delay_timer_pkg::UNIT_CYCLES,
   parameter int                 DELAY_W     = delay_timer_pkg::DELAY_W,
   parameter int                 PAT_W       = delay_timer_pkg::PAT_W,
   parameter logic [PAT_W-1:0]   START_PAT   = delay_timer_pkg::START_PAT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               data,
   input  logic               ack,
   output logic               counting,
   output logic               done,
   output logic [DELAY_W-1:0] count
);

   import delay_timer_pkg::*;

   localparam int CYC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int SH_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;

   state_e             state_q, state_d;
   logic [DELAY_W-1:0] delay_q, delay_d;
   logic [CYC_W-1:0]   cyc_q,   cyc_d;
   logic [SH_W-1:0]    shift_q, shift_d;
   logic               match;

   start_seq_det #(
      .PAT_W     (PAT_W),
      .START_PAT (START_PAT)
   ) u_det (
      .clk    (clk),
      .reset  (reset),
      .enable (state_q == IDLE),
      .data   (data),
      .match  (match)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      cyc_d   = cyc_q;
      shift_d = shift_q;
      unique case (state_q)
         IDLE: begin
            if (match) begin
               state_d = SHIFT;
               delay_d = '0;
               shift_d = '0;
            end
         end
         SHIFT: begin
            delay_d = (delay_q << 1) | DELAY_W'(data);
            if (shift_q == SH_W'(DELAY_W - 1)) begin
               state_d = COUNT;
               cyc_d   = '0;
               shift_d = '0;
            end else begin
               shift_d = shift_q + 1'b1;
            end
         end
         COUNT: begin
            if (cyc_q == CYC_W'(UNIT_CYCLES - 1)) begin
               cyc_d = '0;
               // The last unit ends with delay_q already at zero, so no decrement wraps.
               if (delay_q == '0) begin
                  state_d = DONE;
               end else begin
                  delay_d = delay_q - 1'b1;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         DONE: begin
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         delay_q <= '0;
         cyc_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         delay_q <= delay_d;
         cyc_q   <= cyc_d;
         shift_q <= shift_d;
      end
   end

   // Outputs decode registered state only, so reset clears them without a clock edge.
   assign counting = (state_q == COUNT);
   assign done     = (state_q == DONE);
   assign count    = counting ? delay_q : '0;

endmodule : delay_timer

// File: doc/delay_timer.md
DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 Parameter UNIT_CYCLES, default 1000, clock cycles per delay unit.
REQ-002 Parameter DELAY_W, default 4, width of the serially loaded delay field.
REQ-003 Parameter START_PAT, default 4'b1101, serial start pattern, first bit received is the MSB.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 data  input  1  serial stream carrying the start pattern followed by the delay field, MSB first.
REQ-007 ack  input  1  consumer acknowledge of done.
REQ-008 counting  output  1  high while the timed interval runs.
REQ-009 done  output  1  high from interval expiry until acknowledged.
REQ-010 count  output  DELAY_W  remaining whole delay units during the interval.

Function
REQ-011 The FSM SHALL have four states: IDLE, SHIFT, COUNT and DONE.
REQ-012 In IDLE, the block SHALL sample data every edge into a START_PAT-wide history and detect overlapping matches.
  - On the edge that samples the final pattern bit, the next state is SHIFT.
REQ-013 SHIFT SHALL last exactly DELAY_W cycles, shifting data MSB-first into the delay register, then enter COUNT.
REQ-014 On entry to COUNT, count SHALL equal the loaded delay and the internal cycle counter SHALL be 0.
REQ-015 In COUNT, the cycle counter SHALL step 0..UNIT_CYCLES-1; at UNIT_CYCLES-1 it wraps to 0 and count decrements by 1.
REQ-016 On the edge where the cycle counter is UNIT_CYCLES-1 and count is 0, the block SHALL enter DONE; counting is high for exactly (delay+1)*UNIT_CYCLES cycles.
REQ-017 counting SHALL be high only in COUNT, done high only in DONE, and count 0 in every state except COUNT.
REQ-018 In DONE, ack=1 at an edge SHALL return the FSM to IDLE; ack is ignored in all other states.
REQ-019 If ack is already high on DONE entry, done SHALL be high for exactly one cycle.
REQ-020 data SHALL be ignored outside IDLE, and the pattern history SHALL clear on leaving IDLE, so no bits sampled in SHIFT, COUNT or DONE contribute to a later match.
REQ-021 The cycle counter width SHALL be ceil(log2(UNIT_CYCLES)) bits (10 at the default); count arithmetic SHALL never underflow.

Reset
REQ-022 reset=0 SHALL immediately, without waiting for clk, force the following values:
  - state = IDLE;
  - counting, done and count = 0;
  - cycle counter, delay register and pattern history = 0.
REQ-023 Reset asserted mid-SHIFT or mid-COUNT SHALL abandon the operation; after release, a full new pattern is required.
REQ-024 The first active edge after reset release SHALL sample data as a normal IDLE cycle.

Structure
REQ-025 A shared package SHALL hold the state enum type and the default constants:
  - UNIT_CYCLES = 1000;
  - DELAY_W = 4;
  - START_PAT = 4'b1101.
REQ-026 Pattern detection SHALL be one sub-module, start_seq_det, with these ports:
  - inputs clk, reset, enable and data;
  - output match, a one-cycle pulse.
REQ-027 The FSM, delay shift register and unit counter SHALL reside in delay_timer.

Verification
REQ-028 Delay 0:
  - stimulus: data 1,1,0,1 then 0,0,0,0;
  - response: counting high for exactly 1000 cycles with count=0, then done=1.
REQ-029 Delay 5:
  - stimulus: data 1,1,0,1,0,1,0,1;
  - response: count holds 5,4,3,2,1,0 for 1000 cycles each, counting high for 6000 cycles total, then done=1.
REQ-030 Overlap:
  - stimulus: data 1,1,1,0,1 then 1,1,1,1;
  - response: match on the 5th bit, delay=15, counting high for 16000 cycles.
REQ-031 Ack handling:
  - stimulus: ack=1 during COUNT, then ack=0 for 3 cycles in DONE, then ack=1;
  - response: done stays high until the ack=1 edge, then the FSM returns to IDLE; a new pattern restarts correctly.
REQ-032 Reset mid-operation:
  - stimulus: reset=0 asynchronously at cycle 2500 of a delay-3 interval;
  - response: counting, done and count drop to 0 immediately without a clock edge.
  - no false match occurs on the next 3 data bits 1,0,1.
REQ-033 Ack pre-asserted:
  - stimulus: ack held high through expiry;
  - response: done=1 for exactly one cycle.
